// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared types, LED codes and decode helpers for motor_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_FWD,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        TURN_L,
        TURN_R,
        BRAKE
    } state_t;

    localparam logic [2:0] LED_IDLE   = 3'b100;
    localparam logic [2:0] LED_FWD    = 3'b011;
    localparam logic [2:0] LED_TURN_L = 3'b001;
    localparam logic [2:0] LED_TURN_R = 3'b010;
    localparam logic [2:0] LED_BRAKE  = 3'b100;

    function automatic dir_t bin_to_dir(input logic [3:0] bin, input logic recognised);
        dir_t d;
        if (!recognised) begin
            d = DIR_NONE;
        end else if (bin >= 4'd3 && bin <= 4'd5) begin
            d = DIR_FWD;
        end else if (bin >= 4'd6 && bin <= 4'd11) begin
            d = DIR_LEFT;
        end else begin
            d = DIR_RIGHT;
        end
        return d;
    endfunction

    function automatic state_t dir_to_state(input dir_t d);
        state_t s;
        case (d)
            DIR_FWD:   s = FWD;
            DIR_LEFT:  s = TURN_L;
            DIR_RIGHT: s = TURN_R;
            default:   s = IDLE;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] state_led(input state_t s);
        logic [2:0] l;
        case (s)
            FWD:     l = LED_FWD;
            TURN_L:  l = LED_TURN_L;
            TURN_R:  l = LED_TURN_R;
            BRAKE:   l = LED_BRAKE;
            default: l = LED_IDLE;
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/speed_ramp.sv
`default_nettype none
// ============================================================================
// Module      : speed_ramp
// Description : Moves one wheel speed toward its target by at most RAMP_STEP
//               per tick, never overshooting.
// Revision    : 1.0 - initial release
// ============================================================================
module speed_ramp #(
    parameter int RAMP_STEP = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tick,
    input  logic [14:0] target,
    output logic [14:0] speed,
    output logic        at_target
);

    localparam logic [14:0] c_STEP = 15'(RAMP_STEP);

    logic [14:0] w_diff;
    logic [14:0] w_step;

    always_comb begin
        w_diff = (target >= speed) ? (target - speed) : (speed - target);
        w_step = (w_diff > c_STEP) ? c_STEP : w_diff;
    end

    assign at_target = (speed == target);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            speed <= '0;
        end else if (tick) begin
            if (target > speed) begin
                speed <= speed + w_step;
            end else begin
                speed <= speed - w_step;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/motor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : motor_sequencer
// Description : Debounced direction FSM with braking, turn/timeout limits and
//               ramped wheel speeds for the two DC-motor channels.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_sequencer
    import motor_pkg::*;
#(
    parameter int SPEED_MAX      = 4915,
    parameter int RAMP_STEP      = 64,
    parameter int RAMP_DIV       = 983,
    parameter int TURN_CYCLES    = 49_152_000,
    parameter int TIMEOUT_CYCLES = 98_304_000,
    parameter int HOLD_FRAMES    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid,
    input  logic [3:0]  bin,
    input  logic        recognised,
    output logic [14:0] speed_left,
    output logic [14:0] speed_right,
    output logic [2:0]  led,
    output logic        busy
);

    localparam int          c_DIV_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int          c_TURN_W    = $clog2(TURN_CYCLES + 1);
    localparam int          c_TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int          c_HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [14:0] c_SPEED_MAX = 15'(SPEED_MAX);

    logic [c_DIV_W-1:0]  r_div_cnt;
    logic                w_tick;
    dir_t                w_dir;
    dir_t                r_deb_dir;
    logic [c_HOLD_W-1:0] r_deb_cnt;
    logic [c_HOLD_W-1:0] w_deb_cnt_nxt;
    logic                w_accept;
    state_t              r_state;
    state_t              w_state_nxt;
    dir_t                r_pending;
    dir_t                w_pending_nxt;
    logic                w_clr_timers;
    logic                w_motion;
    logic                w_turning;
    logic                w_turn_exp;
    logic                w_tmo_exp;
    logic [c_TURN_W-1:0] r_turn_cnt;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [14:0]         w_target_l;
    logic [14:0]         w_target_r;
    logic                w_at_l;
    logic                w_at_r;

    // Free-running ramp-tick divider
    assign w_tick = (r_div_cnt == c_DIV_W'(RAMP_DIV - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    assign w_dir = bin_to_dir(bin, recognised);

    always_comb begin
        w_deb_cnt_nxt = r_deb_cnt;
        if (w_dir != r_deb_dir) begin
            w_deb_cnt_nxt = c_HOLD_W'(1);
        end else if (r_deb_cnt != c_HOLD_W'(HOLD_FRAMES)) begin
            w_deb_cnt_nxt = r_deb_cnt + c_HOLD_W'(1);
        end
    end

    assign w_accept = cmd_valid && (w_deb_cnt_nxt == c_HOLD_W'(HOLD_FRAMES));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_deb_dir <= DIR_NONE;
            r_deb_cnt <= '0;
        end else if (cmd_valid) begin
            r_deb_dir <= w_dir;
            r_deb_cnt <= w_deb_cnt_nxt;
        end
    end

    assign w_motion   = (r_state == FWD) || (r_state == TURN_L) || (r_state == TURN_R);
    assign w_turning  = (r_state == TURN_L) || (r_state == TURN_R);
    assign w_turn_exp = w_turning && (r_turn_cnt == c_TURN_W'(TURN_CYCLES - 1));
    assign w_tmo_exp  = w_motion && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    // An accepted command always takes priority over turn expiry and timeout
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_clr_timers  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_dir != DIR_NONE) begin
                    w_state_nxt = dir_to_state(w_dir);
                end
            end
            FWD, TURN_L, TURN_R: begin
                if (w_accept) begin
                    if (dir_to_state(w_dir) == r_state) begin
                        w_clr_timers = 1'b1;
                    end else begin
                        w_state_nxt   = BRAKE;
                        w_pending_nxt = w_dir;
                    end
                end else if (w_turn_exp || w_tmo_exp) begin
                    w_state_nxt   = BRAKE;
                    w_pending_nxt = DIR_NONE;
                end
            end
            BRAKE: begin
                if (w_accept) begin
                    w_pending_nxt = w_dir;
                end
                if (w_at_l && w_at_r) begin
                    w_state_nxt   = dir_to_state(w_pending_nxt);
                    w_pending_nxt = DIR_NONE;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = DIR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_pending  <= DIR_NONE;
            led        <= LED_IDLE;
            busy       <= 1'b0;
            r_turn_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            led       <= state_led(w_state_nxt);
            busy      <= (w_state_nxt != IDLE);
            if (w_state_nxt != r_state || w_clr_timers) begin
                r_turn_cnt <= '0;
                r_tmo_cnt  <= '0;
            end else begin
                if (w_motion) begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                end
                if (w_turning) begin
                    r_turn_cnt <= r_turn_cnt + c_TURN_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_target_l = '0;
        w_target_r = '0;
        case (r_state)
            FWD: begin
                w_target_l = c_SPEED_MAX;
                w_target_r = c_SPEED_MAX;
            end
            TURN_L: w_target_r = c_SPEED_MAX;
            TURN_R: w_target_l = c_SPEED_MAX;
            default: begin
                w_target_l = '0;
                w_target_r = '0;
            end
        endcase
    end

    speed_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp_left (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .tick      (w_tick),
        .target    (w_target_l),
        .speed     (speed_left),
        .at_target (w_at_l)
    );

    speed_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp_right (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .tick      (w_tick),
        .target    (w_target_r),
        .speed     (speed_right),
        .at_target (w_at_r)
    );

endmodule
`default_nettype wire

// File: tb/tb_motor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_sequencer
// Description : Scoreboard bench for motor_sequencer; expected output changes
//               are queued per channel and matched by an edge-driven monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_sequencer;

    logic        clk_in     = 1'b0;
    logic        rst_in     = 1'b0;
    logic        cmd_valid  = 1'b0;
    logic [3:0]  bin        = 4'd0;
    logic        recognised = 1'b0;
    logic [14:0] speed_left;
    logic [14:0] speed_right;
    logic [2:0]  led;
    logic        busy;

    motor_sequencer #(
        .SPEED_MAX      (100),
        .RAMP_STEP      (30),
        .RAMP_DIV       (4),
        .TURN_CYCLES    (50),
        .TIMEOUT_CYCLES (200),
        .HOLD_FRAMES    (2)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cmd_valid   (cmd_valid),
        .bin         (bin),
        .recognised  (recognised),
        .speed_left  (speed_left),
        .speed_right (speed_right),
        .led         (led),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t       q_led[$];
    exp_t       q_left[$];
    exp_t       q_right[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         last_edge = 0;
    bit         mon_en = 1'b0;
    int         last_lb;
    int         last_l;
    int         last_r;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic compare_event(input string name, input bit have, input exp_t e, input int act);
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL %s unexpected change actual=%0d at cycle %0d", name, act, cyc);
        end else if (act != e.val || (e.cyc >= 0 && cyc != e.cyc)) begin
            failures++;
            $display("FAIL %s actual=%0d@%0d required=%0d@%0d", name, act, cyc, e.val, e.cyc);
        end
    endtask

    // Monitor: every change on a channel consumes one queued expectation
    always @(posedge clk_in) begin
        #1;
        if (mon_en) begin
            if (int'({led, busy}) != last_lb) begin
                if (q_led.size() == 0) compare_event("led_busy", 1'b0, '{0, -1}, int'({led, busy}));
                else compare_event("led_busy", 1'b1, q_led.pop_front(), int'({led, busy}));
                last_lb = int'({led, busy});
            end
            if (int'(speed_left) != last_l) begin
                if (q_left.size() == 0) compare_event("speed_left", 1'b0, '{0, -1}, int'(speed_left));
                else compare_event("speed_left", 1'b1, q_left.pop_front(), int'(speed_left));
                last_l = int'(speed_left);
            end
            if (int'(speed_right) != last_r) begin
                if (q_right.size() == 0) compare_event("speed_right", 1'b0, '{0, -1}, int'(speed_right));
                else compare_event("speed_right", 1'b1, q_right.pop_front(), int'(speed_right));
                last_r = int'(speed_right);
            end
        end
    end

    task automatic exp_led(input logic [2:0] l, input logic b, input int c);
        q_led.push_back('{int'({l, b}), c});
    endtask

    task automatic exp_spd(input bit left, input bit right, input int v);
        if (left)  q_left.push_back('{v, -1});
        if (right) q_right.push_back('{v, -1});
    endtask

    task automatic ramp_up(input bit left, input bit right);
        exp_spd(left, right, 30);
        exp_spd(left, right, 60);
        exp_spd(left, right, 90);
        exp_spd(left, right, 100);
    endtask

    task automatic ramp_down(input bit left, input bit right);
        exp_spd(left, right, 70);
        exp_spd(left, right, 40);
        exp_spd(left, right, 10);
        exp_spd(left, right, 0);
    endtask

    // Called at a negedge; the strobe is sampled on the next posedge
    task automatic strobe(input logic [3:0] b, input logic rec, input bit push, input logic [2:0] l);
        cmd_valid  = 1'b1;
        bin        = b;
        recognised = rec;
        last_edge  = cyc + 1;
        if (push) exp_led(l, 1'b1, last_edge);
        @(negedge clk_in);
        cmd_valid  = 1'b0;
        recognised = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((q_led.size() != 0 || q_left.size() != 0 || q_right.size() != 0) && n < max_cycles) begin
            @(negedge clk_in);
            n++;
        end
        check(name, q_led.size() + q_left.size() + q_right.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n2;
        int n;

        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_led", int'(led), 4);
        check("reset_busy", int'(busy), 0);
        check("reset_left", int'(speed_left), 0);
        check("reset_right", int'(speed_right), 0);
        rst_in  = 1'b1;
        last_lb = int'({led, busy});
        last_l  = int'(speed_left);
        last_r  = int'(speed_right);
        mon_en  = 1'b1;
        @(negedge clk_in);

        // 1: forward from idle
        ramp_up(1'b1, 1'b1);
        strobe(4'd4, 1'b1, 1'b0, 3'b000);
        strobe(4'd4, 1'b1, 1'b1, 3'b011);
        wait_drain("t1_drain", 80);
        check("t1_led", int'(led), 3);

        // 3: forward -> brake -> left turn -> turn expiry -> idle
        ramp_down(1'b1, 1'b1);
        ramp_up(1'b0, 1'b1);
        ramp_down(1'b0, 1'b1);
        strobe(4'd8, 1'b1, 1'b0, 3'b000);
        strobe(4'd8, 1'b1, 1'b1, 3'b100);
        exp_led(3'b001, 1'b1, -1);
        exp_led(3'b100, 1'b1, -1);
        exp_led(3'b100, 1'b0, -1);
        wait_drain("t3_drain", 250);

        // 2: disagreeing strobes never accept
        strobe(4'd8, 1'b0, 1'b0, 3'b000);
        strobe(4'd8, 1'b1, 1'b0, 3'b000);
        strobe(4'd4, 1'b1, 1'b0, 3'b000);
        repeat (20) @(negedge clk_in);
        check("t2_led", int'(led), 4);
        check("t2_busy", int'(busy), 0);
        check("t2_left", int'(speed_left), 0);
        check("t2_right", int'(speed_right), 0);

        // 4: right turn bounded to 50 cycles
        ramp_up(1'b1, 1'b0);
        ramp_down(1'b1, 1'b0);
        strobe(4'd13, 1'b1, 1'b0, 3'b000);
        strobe(4'd13, 1'b1, 1'b1, 3'b010);
        exp_led(3'b100, 1'b1, last_edge + 50);
        exp_led(3'b100, 1'b0, -1);
        wait_drain("t4_drain", 250);
        check("t4_busy", int'(busy), 0);

        // 5a: command timeout from forward
        ramp_up(1'b1, 1'b1);
        ramp_down(1'b1, 1'b1);
        strobe(4'd4, 1'b1, 1'b0, 3'b000);
        strobe(4'd4, 1'b1, 1'b1, 3'b011);
        exp_led(3'b100, 1'b1, last_edge + 200);
        exp_led(3'b100, 1'b0, -1);
        wait_drain("t5a_drain", 400);

        // 5b: accepted command on the timeout cycle wins
        ramp_up(1'b1, 1'b1);
        strobe(4'd4, 1'b1, 1'b1, 3'b011);
        n2 = last_edge;
        wait_drain("t5b_ramp", 80);
        while (cyc < n2 + 199) @(negedge clk_in);
        strobe(4'd4, 1'b1, 1'b0, 3'b000);
        check("t5b_led_after", int'(led), 3);
        ramp_down(1'b1, 1'b1);
        exp_led(3'b100, 1'b1, n2 + 400);
        exp_led(3'b100, 1'b0, -1);
        wait_drain("t5b_drain", 400);

        // 6: asynchronous reset mid-ramp
        exp_spd(1'b1, 1'b1, 30);
        exp_spd(1'b1, 1'b1, 60);
        strobe(4'd4, 1'b1, 1'b1, 3'b011);
        n = 0;
        while (!(speed_left == 15'd60 && speed_right == 15'd60) && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        check("t6_mid_left", int'(speed_left), 60);
        exp_led(3'b100, 1'b0, -1);
        exp_spd(1'b1, 1'b1, 0);
        #1;
        rst_in = 1'b0;
        #1;
        check("t6_async_left", int'(speed_left), 0);
        check("t6_async_right", int'(speed_right), 0);
        check("t6_async_led", int'(led), 4);
        check("t6_async_busy", int'(busy), 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        wait_drain("t6_drain", 20);
        repeat (10) @(negedge clk_in);
        check("t6_post_led", int'(led), 4);
        check("t6_post_left", int'(speed_left), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
